// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants for the CPU controller: FSM state
//               encodings, opcode and sub-op values, ALU operation codes.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // FSM state encoding
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] WAIT      = 3'd0;
    localparam logic [STATE_W-1:0] DECODE    = 3'd1;
    localparam logic [STATE_W-1:0] GET_A     = 3'd2;
    localparam logic [STATE_W-1:0] GET_B     = 3'd3;
    localparam logic [STATE_W-1:0] ALU       = 3'd4;
    localparam logic [STATE_W-1:0] WRITE_REG = 3'd5;
    localparam logic [STATE_W-1:0] WRITE_IMM = 3'd6;

    // Opcode classes (IR[15:13])
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // ALU operations (IR[12:11] for the ALU class)
    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] CMP = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] MVN = 2'b11;

    // MOV sub-operations (IR[12:11] for the MOV class)
    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_decode
// Description : Combinational instruction decoder. Splits the instruction
//               register into operand fields, sign-extends the 8-bit
//               immediate and classifies the instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] sximm8,
    output logic        is_mov_imm,
    output logic        is_mov_reg,
    output logic        is_alu,
    output logic        is_mvn,
    output logic        is_cmp,
    output logic        needs_a
);

    logic [2:0] w_opcode;

    assign w_opcode = ir[15:13];
    assign op       = ir[12:11];
    assign rn       = ir[10:8];
    assign rd       = ir[7:5];
    assign sh       = ir[4:3];
    assign rm       = ir[2:0];
    assign sximm8   = {{8{ir[7]}}, ir[7:0]};

    // Instruction classes; anything not matched here is a no-op return to WAIT
    assign is_mov_imm = (w_opcode == OPC_MOV) && (op == MOV_IMM);
    assign is_mov_reg = (w_opcode == OPC_MOV) && (op == MOV_REG);
    assign is_alu     = (w_opcode == OPC_ALU);
    assign is_mvn     = is_alu && (op == MVN);
    assign is_cmp     = is_alu && (op == CMP);
    // Two-operand ALU ops fetch Rn into A; MVN and MOV reg use only B
    assign needs_a    = is_alu && (op != MVN);

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl
// Description : Instruction register plus Moore controller FSM sequencing
//               register-file reads/writes and datapath load strobes for
//               MOV imm, MOV reg, ADD, CMP, AND and MVN.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s,
    input  logic               load,
    input  logic [INSTR_W-1:0] in,
    output logic               w,
    output logic [REG_AW-1:0]  readnum,
    output logic [REG_AW-1:0]  writenum,
    output logic               write,
    output logic               loada,
    output logic               loadb,
    output logic               loadc,
    output logic               loads,
    output logic               asel,
    output logic               bsel,
    output logic               vsel,
    output logic [1:0]         shift,
    output logic [1:0]         ALUop,
    output logic [INSTR_W-1:0] sximm8
);

    logic [STATE_W-1:0] r_state;
    logic [INSTR_W-1:0] r_ir;

    logic [1:0]        w_op;
    logic [REG_AW-1:0] w_rn;
    logic [REG_AW-1:0] w_rd;
    logic [1:0]        w_sh;
    logic [REG_AW-1:0] w_rm;
    logic              w_is_mov_imm;
    logic              w_is_mov_reg;
    logic              w_is_alu;
    logic              w_is_mvn;
    logic              w_is_cmp;
    logic              w_needs_a;
    logic              w_strobe_en;

    cpu_ctrl_decode u_decode (
        .ir         (r_ir),
        .op         (w_op),
        .rn         (w_rn),
        .rd         (w_rd),
        .sh         (w_sh),
        .rm         (w_rm),
        .sximm8     (sximm8),
        .is_mov_imm (w_is_mov_imm),
        .is_mov_reg (w_is_mov_reg),
        .is_alu     (w_is_alu),
        .is_mvn     (w_is_mvn),
        .is_cmp     (w_is_cmp),
        .needs_a    (w_needs_a)
    );

    // State sequencing and instruction register; IR only loads while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT;
            r_ir    <= '0;
        end else begin
            case (r_state)
                WAIT: begin
                    if (load) r_ir    <= in;
                    if (s)    r_state <= DECODE;
                end
                DECODE: begin
                    if (w_is_mov_imm)                 r_state <= WRITE_IMM;
                    else if (w_is_mov_reg || w_is_mvn) r_state <= GET_B;
                    else if (w_needs_a)               r_state <= GET_A;
                    else                              r_state <= WAIT;
                end
                GET_A:     r_state <= GET_B;
                GET_B:     r_state <= ALU;
                ALU:       r_state <= w_is_cmp ? WAIT : WRITE_REG;
                WRITE_REG: r_state <= WAIT;
                WRITE_IMM: r_state <= WAIT;
                default:   r_state <= WAIT;
            endcase
        end
    end

    // Reset masks every strobe so a mid-instruction reset commits nothing
    assign w_strobe_en = ~reset;

    // Moore output decode from current state and IR fields
    always_comb begin
        w        = (r_state == WAIT);
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (r_state)
            GET_A: begin
                readnum = w_rn;
                loada   = w_strobe_en;
            end
            GET_B: begin
                readnum = w_rm;
                loadb   = w_strobe_en;
            end
            ALU: begin
                shift = w_sh;
                ALUop = w_is_alu ? w_op : ADD;
                asel  = w_is_mov_reg || w_is_mvn;
                if (w_is_cmp) loads = w_strobe_en;
                else          loadc = w_strobe_en;
            end
            WRITE_REG: begin
                writenum = w_rd;
                write    = w_strobe_en;
            end
            WRITE_IMM: begin
                writenum = w_rn;
                vsel     = 1'b1;
                write    = w_strobe_en;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_ctrl
// Description : Self-checking bench for cpu_ctrl: vector table, directed
//               multi-cycle corner cases and randomized instructions checked
//               against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;

    cpu_ctrl #(.INSTR_W(16), .REG_AW(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .load     (load),
        .in       (in),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8)
    );

    always #5 clk = ~clk;

    // Observed / expected summary of one executed instruction
    typedef struct {
        int lat;
        int a_cnt;  int a_idx;
        int b_cnt;  int b_idx;
        int alu_cnt; int shift; int aluop; int asel; int loads; int loadc;
        int wr_cnt; int wnum; int vsel; int wdata;
        int ir_stable;
        int sx_end;
        int bsel_seen;
    } obs_t;

    typedef struct {
        logic [15:0] instr;
        int lat; int wr; int wnum; int vsel; int sx;
    } vec_t;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      name, act, act, exp, exp);
    endtask

    // Sign-extended 8-bit immediate, by arithmetic
    function automatic int sext(input logic [15:0] ir);
        int x;
        x = int'(ir[7:0]);
        if (x >= 128) x = x - 256;
        return x & 32'hFFFF;
    endfunction

    // Instruction-level reference model built from the ISA rules
    function automatic obs_t model(input logic [15:0] ir);
        obs_t e;
        int opc, op, rn, rd, sh, rm;
        e = '{default:0};
        opc = int'(ir[15:13]); op = int'(ir[12:11]);
        rn = int'(ir[10:8]); rd = int'(ir[7:5]);
        sh = int'(ir[4:3]);  rm = int'(ir[2:0]);
        e.ir_stable = 1;
        e.sx_end = sext(ir);
        e.lat = 2;
        if (opc == 6 && op == 2) begin
            e.lat = 3;
            e.wr_cnt = 1; e.wnum = rn; e.vsel = 1; e.wdata = sext(ir);
        end else if ((opc == 6 && op == 0) || opc == 5) begin
            if (opc == 5 && op != 3) begin e.a_cnt = 1; e.a_idx = rn; end
            e.b_cnt = 1; e.b_idx = rm;
            e.alu_cnt = 1; e.shift = sh;
            e.aluop = (opc == 6) ? 0 : op;
            e.asel  = (opc == 6 || op == 3) ? 1 : 0;
            if (opc == 5 && op == 1) begin
                e.loads = 1; e.lat = 5;
            end else begin
                e.loadc = 1;
                e.wr_cnt = 1; e.wnum = rd; e.vsel = 0; e.wdata = sext(ir);
                e.lat = (opc == 6 || op == 3) ? 5 : 6;
            end
        end
        return e;
    endfunction

    task automatic drive_busy(input bit noise);
        if (noise) begin
            s    = 1'($urandom_range(0, 1));
            load = 1'($urandom_range(0, 1));
            in   = 16'($urandom);
        end else begin
            s    = 1'b0;
            load = 1'b0;
        end
    endtask

    // Load + start an instruction, then trace strobes until w returns
    task automatic exec(input logic [15:0] instr, input bit noise, output obs_t o);
        int  n;
        bit  done;
        o = '{default:0};
        o.ir_stable = 1;
        o.lat = 99;
        @(posedge clk); #1;
        in = instr; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        n = 1;
        drive_busy(noise);
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (int'(sximm8) != sext(instr)) o.ir_stable = 0;
            if (bsel) o.bsel_seen = 1;
            if (w) begin
                o.lat = n;
                o.sx_end = int'(sximm8);
                s = 1'b0; load = 1'b0;
                done = 1'b1;
            end else begin
                if (loada) begin o.a_cnt++; o.a_idx = int'(readnum); end
                if (loadb) begin o.b_cnt++; o.b_idx = int'(readnum); end
                if (loadc || loads) begin
                    o.alu_cnt++;
                    o.shift = int'(shift); o.aluop = int'(ALUop);
                    o.asel = int'(asel); o.loads = int'(loads); o.loadc = int'(loadc);
                end
                if (write) begin
                    o.wr_cnt++; o.wnum = int'(writenum);
                    o.vsel = int'(vsel); o.wdata = int'(sximm8);
                end
                if (n >= 20) begin
                    s = 1'b0; load = 1'b0; reset = 1'b1;
                    @(posedge clk); #1;
                    reset = 1'b0;
                    done = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    n++;
                    drive_busy(noise);
                end
            end
        end
    endtask

    task automatic compare(input string name, input obs_t o, input obs_t e);
        chk({name, ".lat"},     o.lat,     e.lat);
        chk({name, ".a_cnt"},   o.a_cnt,   e.a_cnt);
        chk({name, ".a_idx"},   o.a_idx,   e.a_idx);
        chk({name, ".b_cnt"},   o.b_cnt,   e.b_cnt);
        chk({name, ".b_idx"},   o.b_idx,   e.b_idx);
        chk({name, ".alu_cnt"}, o.alu_cnt, e.alu_cnt);
        chk({name, ".shift"},   o.shift,   e.shift);
        chk({name, ".aluop"},   o.aluop,   e.aluop);
        chk({name, ".asel"},    o.asel,    e.asel);
        chk({name, ".loads"},   o.loads,   e.loads);
        chk({name, ".loadc"},   o.loadc,   e.loadc);
        chk({name, ".wr_cnt"},  o.wr_cnt,  e.wr_cnt);
        chk({name, ".wnum"},    o.wnum,    e.wnum);
        chk({name, ".vsel"},    o.vsel,    e.vsel);
        chk({name, ".wdata"},   o.wdata,   e.wdata);
        chk({name, ".ir_stable"}, o.ir_stable, e.ir_stable);
        chk({name, ".sx_end"},  o.sx_end,  e.sx_end);
        chk({name, ".bsel"},    o.bsel_seen, 0);
    endtask

    initial begin
        vec_t        tbl [9];
        obs_t        o;
        logic [15:0] r;
        bit          seen;

        tbl[0] = '{16'hD207, 3, 1, 2, 1, 32'h0007};  // MOV R2,#7
        tbl[1] = '{16'hD0FF, 3, 1, 0, 1, 32'hFFFF};  // MOV R0,#-1
        tbl[2] = '{16'hA16A, 6, 1, 3, 0, 32'h006A};  // ADD R3,R1,R2,LSL#1
        tbl[3] = '{16'hA902, 5, 0, 0, 0, 32'h0002};  // CMP R1,R2
        tbl[4] = '{16'hC0B6, 5, 1, 5, 0, 32'hFFB6};  // MOV R5,R6,LSR#1
        tbl[5] = '{16'hB824, 5, 1, 1, 0, 32'h0024};  // MVN R1,R4
        tbl[6] = '{16'hB0E1, 6, 1, 7, 0, 32'hFFE1};  // AND R7,R0,R1
        tbl[7] = '{16'h0000, 2, 0, 0, 0, 32'h0000};  // unsupported opcode
        tbl[8] = '{16'hC800, 2, 0, 0, 0, 32'h0000};  // MOV class, bad sub-op

        // Reset and idle
        reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.w", int'(w), 1);
        chk("rst.strobes", int'({write, loada, loadb, loadc, loads}), 0);
        chk("rst.sel", int'({asel, bsel, vsel, shift, ALUop}), 0);
        chk("rst.nums", int'({readnum, writenum}), 0);
        chk("rst.sximm8", int'(sximm8), 0);
        reset = 1'b0;
        seen = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!w || write) seen = 1'b0;
        end
        chk("idle.w_held", int'(seen), 1);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            exec(tbl[i].instr, 1'b0, o);
            chk($sformatf("vec%0d.lat", i),  o.lat,    tbl[i].lat);
            chk($sformatf("vec%0d.wr", i),   o.wr_cnt, tbl[i].wr);
            chk($sformatf("vec%0d.wnum", i), o.wnum,   tbl[i].wnum);
            chk($sformatf("vec%0d.vsel", i), o.vsel,   tbl[i].vsel);
            chk($sformatf("vec%0d.sx", i),   o.sx_end, tbl[i].sx);
            compare($sformatf("vec%0d", i), o, model(tbl[i].instr));
        end

        // ADD detail, with noisy s/load/in while busy
        exec(16'hA16A, 1'b1, o);
        chk("add.a_idx", o.a_idx, 1);
        chk("add.b_idx", o.b_idx, 2);
        chk("add.shift", o.shift, 1);
        chk("add.asel",  o.asel,  0);
        chk("add.wnum",  o.wnum,  3);
        chk("add.ir_unchanged", o.sx_end, 32'h006A);

        // Reset together with load in GET_B
        @(posedge clk); #1;
        in = 16'hA16A; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b0;
        @(posedge clk); #1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.loadb_pre", int'(loadb), 1);
        reset = 1'b1; load = 1'b1; in = 16'hD0FF;
        #1;
        chk("midrst.loadb", int'(loadb), 0);
        chk("midrst.strobes", int'({write, loada, loadc, loads}), 0);
        @(posedge clk); #1;
        chk("midrst.w", int'(w), 1);
        chk("midrst.ir", int'(sximm8), 0);
        reset = 1'b0; load = 1'b0;

        // s held high relaunches after one WAIT cycle
        @(posedge clk); #1;
        in = 16'hD207; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold.w_wait", int'(w), 1);
        @(posedge clk); #1;
        chk("hold.w_relaunch", int'(w), 0);
        s = 1'b0;
        @(posedge clk); #1;
        chk("hold.write", int'(write), 1);
        chk("hold.wnum", int'(writenum), 2);
        @(posedge clk); #1;
        chk("hold.w_end", int'(w), 1);

        // Randomized instructions against the model
        for (int i = 0; i < 40; i++) begin
            r = 16'($urandom);
            case ($urandom_range(0, 4))
                0: begin r[15:13] = 3'b110; r[12:11] = 2'b10; end
                1: begin r[15:13] = 3'b110; r[12:11] = 2'b00; end
                2, 3: r[15:13] = 3'b101;
                default: ;
            endcase
            exec(r, 1'($urandom_range(0, 1)), o);
            compare($sformatf("rnd%0d_%04h", i, r), o, model(r));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Instruction register plus Moore controller FSM sitting directly upstream of the 8x16 register file and datapath.
- Latches a 16-bit instruction, decodes it, and sequences regfile reads and writes (readnum, writenum, write) and datapath load/select strobes over multiple cycles.
- Handshakes with the host through a start pulse s and a wait flag w.
- Supports MOV Rn,#imm8; MOV Rd,Rm{,sh}; ADD; CMP; AND; MVN.

Parameters:
- INSTR_W, 16, instruction and datapath word width.
- REG_AW, 3, register-number width (8 registers).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- s  in  1  start; sampled only in WAIT
- load  in  1  instruction register load enable; honoured only in WAIT
- in  in  16  instruction word
- w  out  1  high iff FSM in WAIT
- readnum  out  3  regfile read select
- writenum  out  3  regfile write select
- write  out  1  regfile write enable
- loada  out  1  datapath A load
- loadb  out  1  datapath B load
- loadc  out  1  datapath C load
- loads  out  1  status register load
- asel  out  1  1 = A operand forced to 0
- bsel  out  1  reserved, always 0
- vsel  out  1  regfile write data: 0 = C result, 1 = sximm8
- shift  out  2  shifter op
- ALUop  out  2  ALU op
- sximm8  out  16  sign-extended IR[7:0], continuously driven

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset effect: at the clk edge with reset=1, state goes to WAIT and IR goes to 0.
- Reset gating: while reset=1, write, loada, loadb, loadc and loads are forced to 0 combinationally, so no regfile write or datapath load occurs at the reset edge, even mid-instruction.
- Values after reset: w=1; every other output is 0 except sximm8, which is 0x0000.
- IR field map:
  - opcode = IR[15:13], op = IR[12:11]
  - Rn = IR[10:8], Rd = IR[7:5]
  - sh = IR[4:3], Rm = IR[2:0]
  - imm8 = IR[7:0]
- IR loads from in on a clk edge when load=1 and state is WAIT; load is ignored in every other state.
- Outputs are Moore, decoded from state and IR. Outside the listed assertions: all strobes 0, readnum/writenum/shift/ALUop = 0, asel=0, vsel=0.
- FSM states and transitions:
  - WAIT: w=1. If s=1, go to DECODE. If s and load are high together, IR captures the new word and DECODE uses it.
  - DECODE: dispatch only, no strobes.
    - opcode 110, op 10 → WRITE_IMM
    - opcode 110, op 00 → GET_B
    - opcode 101, op 11 (MVN) → GET_B
    - opcode 101, op 00/01/10 → GET_A
    - any other encoding → WAIT, no side effects
  - GET_A: readnum=Rn, loada=1 → GET_B.
  - GET_B: readnum=Rm, loadb=1 → ALU.
  - ALU: shift=sh.
    - ALUop = op for opcode 101; ALUop = 00 for MOV reg.
    - asel=1 for MOV reg and MVN.
    - CMP: loads=1, loadc=0 → WAIT.
    - All other instructions: loadc=1 → WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=0, write=1 → WAIT.
  - WRITE_IMM: writenum=Rn, vsel=1, write=1 → WAIT.
- Latency, counted as clk edges from the edge sampling s to the edge returning to WAIT (w goes high after that edge):
  - MOV imm: 3
  - CMP: 5
  - ADD/AND: 6
  - MOV reg/MVN: 5
- Handshake boundaries:
  - s is ignored outside WAIT.
  - s held high relaunches the same IR on the edge after WAIT is re-entered, i.e. w is high for exactly one cycle.
- sximm8 = {{8{IR[7]}}, IR[7:0]} in all states.

Decomposition:
- Package cpu_pkg holds:
  - state encoding localparams: WAIT, DECODE, GET_A, GET_B, ALU, WRITE_REG, WRITE_IMM
  - opcode constants: OPC_MOV=3'b110, OPC_ALU=3'b101
  - ALUop constants: ADD=00, CMP=01, AND=10, MVN=11
  - MOV sub-op constants: MOV_IMM=10, MOV_REG=00
- Sub-module cpu_ctrl_decode: combinational IR field split, sximm8 extension, and instruction-class flags.

Test Plan:
- Reset and idle:
  - Stimulus: reset=1 for 2 edges, then idle.
  - Required: w=1; write/load*=0; sximm8=0x0000; s=0 keeps WAIT indefinitely.
- MOV R2,#7:
  - Stimulus: load in=0xD207 in WAIT, then pulse s.
  - Required: DECODE, then WRITE_IMM with writenum=2, vsel=1, write=1, sximm8=0x0007; w=1 after the 3rd edge.
- Negative immediate:
  - Stimulus: MOV R0,#-1, in=0xD0FF.
  - Required: sximm8=0xFFFF; write asserted with writenum=0.
- ADD R3,R1,R2,LSL#1:
  - Stimulus: in=0xA16A.
  - Required:
    - GET_A: readnum=1, loada=1
    - GET_B: readnum=2, loadb=1
    - ALU: shift=01, ALUop=00, asel=0, loadc=1
    - WRITE_REG: writenum=3, write=1
  - Then WAIT after 6 edges.
- CMP R1,R2:
  - Stimulus: in=0xA902.
  - Required: the ALU cycle has loads=1, loadc=0; write is never asserted; returns to WAIT after 5 edges.
- Reset and load during execution:
  - Stimulus: start ADD 0xA16A; in GET_B, assert load with in=0xD0FF and reset=1 together.
  - Required: loadb=0 in that cycle, IR=0, next state WAIT. Separately, load while busy leaves IR unchanged.
